// File: rtl/wb_uart_ring_bridge_if.sv
// Bus bundle for the UART ring bridge: CPU Wishbone slave side, RAM Wishbone
// master side, and the RX/TX byte streams.
interface wb_uart_ring_bridge_if #(
  parameter int BITS = 8
);
  logic [31:0]     i_wb_cpu_adr;
  logic [31:0]     i_wb_cpu_dat;
  logic [3:0]      i_wb_cpu_sel;
  logic            i_wb_cpu_we;
  logic            i_wb_cpu_cyc;
  logic [31:0]     o_wb_cpu_rdt;
  logic            o_wb_cpu_ack;
  logic [31:0]     o_wb_mem_adr;
  logic [31:0]     o_wb_mem_dat;
  logic [3:0]      o_wb_mem_sel;
  logic            o_wb_mem_we;
  logic            o_wb_mem_cyc;
  logic [31:0]     i_wb_mem_rdt;
  logic            i_wb_mem_ack;
  logic            i_rx_valid;
  logic [BITS-1:0] i_rx_data;
  logic            o_tx_valid;
  logic [7:0]      o_tx_data;
  logic            i_tx_ready;

  modport slave (
    input  i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
    output o_wb_cpu_rdt, o_wb_cpu_ack,
    output o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
    input  i_wb_mem_rdt, i_wb_mem_ack,
    input  i_rx_valid, i_rx_data,
    output o_tx_valid, o_tx_data,
    input  i_tx_ready
  );

  modport master (
    output i_wb_cpu_adr, i_wb_cpu_dat, i_wb_cpu_sel, i_wb_cpu_we, i_wb_cpu_cyc,
    input  o_wb_cpu_rdt, o_wb_cpu_ack,
    input  o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
    output i_wb_mem_rdt, i_wb_mem_ack,
    output i_rx_valid, i_rx_data,
    input  o_tx_valid, o_tx_data,
    output i_tx_ready
  );
endinterface

// File: rtl/wb_uart_ring_bridge.sv
// Arbitrates SERV memory accesses against buffered UART RX bytes written into a
// circular RAM window, and exposes TX-data and status registers to the CPU.
module wb_uart_ring_bridge #(
  parameter int          BITS       = 8,
  parameter logic [31:0] RING_BASE  = 32'h00C00000,
  parameter int          RING_SIZE  = 65536,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TX_ADR     = 32'h00F00000,
  parameter logic [31:0] STAT_ADR   = 32'h00F00004
) (
  input logic                  i_wb_clk,
  input logic                  i_wb_rst,
  wb_uart_ring_bridge_if.slave bus
);
  localparam int PTR_W = $clog2(RING_SIZE);
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W = FA_W + 1;

  typedef enum logic [1:0] {IDLE, CPU_MEM, RX_WR, MMIO} state_e;
  state_e state_q, state_d;

  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [FA_W-1:0]  fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] ring_ptr_q, ring_ptr_d;
  logic             overflow_q, overflow_d, wrapped_q, wrapped_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [31:0]      cpu_adr_q, cpu_adr_d, cpu_dat_q, cpu_dat_d;
  logic [3:0]       cpu_sel_q, cpu_sel_d;
  logic             cpu_we_q, cpu_we_d;

  logic        fifo_full, fifo_empty, push, pop, drop;
  logic        is_mmio_adr, tx_wr_req, tx_stall, tx_load, stat_wr, grant_cpu;
  logic [7:0]  rx_byte, head;
  logic [31:0] stat_word, ring_off;

  assign rx_byte     = 8'(bus.i_rx_data);
  assign head        = fifo_mem_q[fifo_rd_q];
  assign fifo_full   = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt_q == '0);
  assign pop         = (state_q == RX_WR) && bus.i_wb_mem_ack;
  // A full FIFO still accepts a symbol when the head leaves in the same cycle.
  assign push        = bus.i_rx_valid && (!fifo_full || pop);
  assign drop        = bus.i_rx_valid && fifo_full && !pop;
  assign is_mmio_adr = (bus.i_wb_cpu_adr == TX_ADR) || (bus.i_wb_cpu_adr == STAT_ADR);
  assign tx_wr_req   = (state_q == MMIO) && (bus.i_wb_cpu_adr == TX_ADR) &&
                       bus.i_wb_cpu_we && bus.i_wb_cpu_sel[0];
  assign tx_stall    = tx_wr_req && tx_valid_q;
  assign tx_load     = tx_wr_req && !tx_valid_q;
  assign stat_wr     = (state_q == MMIO) && (bus.i_wb_cpu_adr == STAT_ADR) && bus.i_wb_cpu_we;
  assign grant_cpu   = (state_q == IDLE) && (state_d == CPU_MEM);
  assign stat_word   = {overflow_q, wrapped_q, 6'(fifo_cnt_q), 24'(ring_ptr_q)};
  assign ring_off    = {{(32-PTR_W){1'b0}}, ring_ptr_q[PTR_W-1:2], 2'b00};

  assign bus.o_tx_valid = tx_valid_q;
  assign bus.o_tx_data  = tx_data_q;

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_cnt_q >= CNT_W'(FIFO_DEPTH / 2))    state_d = RX_WR;
        else if (bus.i_wb_cpu_cyc && is_mmio_adr)     state_d = MMIO;
        else if (bus.i_wb_cpu_cyc)                    state_d = CPU_MEM;
        else if (!fifo_empty)                         state_d = RX_WR;
      end
      CPU_MEM: if (bus.i_wb_mem_ack) state_d = IDLE;
      RX_WR:   if (bus.i_wb_mem_ack) state_d = IDLE;
      MMIO:    if (!tx_stall)        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_wb_mem_adr = '0;
    bus.o_wb_mem_dat = '0;
    bus.o_wb_mem_sel = '0;
    bus.o_wb_mem_we  = 1'b0;
    bus.o_wb_mem_cyc = 1'b0;
    bus.o_wb_cpu_rdt = '0;
    bus.o_wb_cpu_ack = 1'b0;
    case (state_q)
      CPU_MEM: begin
        bus.o_wb_mem_adr = cpu_adr_q;
        bus.o_wb_mem_dat = cpu_dat_q;
        bus.o_wb_mem_sel = cpu_sel_q;
        bus.o_wb_mem_we  = cpu_we_q;
        bus.o_wb_mem_cyc = 1'b1;
        bus.o_wb_cpu_rdt = bus.i_wb_mem_rdt;
        bus.o_wb_cpu_ack = bus.i_wb_mem_ack;
      end
      RX_WR: begin
        bus.o_wb_mem_adr = RING_BASE + ring_off;
        bus.o_wb_mem_dat = {4{head}};
        bus.o_wb_mem_sel = 4'b0001 << ring_ptr_q[1:0];
        bus.o_wb_mem_we  = 1'b1;
        bus.o_wb_mem_cyc = 1'b1;
      end
      MMIO: begin
        bus.o_wb_cpu_ack = !tx_stall;
        if (bus.i_wb_cpu_adr == STAT_ADR)    bus.o_wb_cpu_rdt = stat_word;
        else if (bus.i_wb_cpu_adr == TX_ADR) bus.o_wb_cpu_rdt = {31'b0, tx_valid_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    fifo_wr_d  = push ? fifo_wr_q + FA_W'(1) : fifo_wr_q;
    fifo_rd_d  = pop  ? fifo_rd_q + FA_W'(1) : fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    ring_ptr_d = pop ? ring_ptr_q + PTR_W'(1) : ring_ptr_q;

    // Clears are applied first so a coincident set wins.
    overflow_d = overflow_q;
    wrapped_d  = wrapped_q;
    if (stat_wr && bus.i_wb_cpu_dat[31]) overflow_d = 1'b0;
    if (stat_wr && bus.i_wb_cpu_dat[30]) wrapped_d  = 1'b0;
    if (drop)                            overflow_d = 1'b1;
    if (pop && (&ring_ptr_q))            wrapped_d  = 1'b1;

    tx_valid_d = tx_valid_q;
    if (tx_valid_q && bus.i_tx_ready) tx_valid_d = 1'b0;
    if (tx_load)                      tx_valid_d = 1'b1;
    tx_data_d = tx_load ? bus.i_wb_cpu_dat[7:0] : tx_data_q;

    cpu_adr_d = grant_cpu ? bus.i_wb_cpu_adr : cpu_adr_q;
    cpu_dat_d = grant_cpu ? bus.i_wb_cpu_dat : cpu_dat_q;
    cpu_sel_d = grant_cpu ? bus.i_wb_cpu_sel : cpu_sel_q;
    cpu_we_d  = grant_cpu ? bus.i_wb_cpu_we  : cpu_we_q;
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      ring_ptr_q <= '0;
      overflow_q <= 1'b0;
      wrapped_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      ring_ptr_q <= ring_ptr_d;
      overflow_q <= overflow_d;
      wrapped_q  <= wrapped_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Payload storage carries no reset; it is only observed behind valid control state.
  always_ff @(posedge i_wb_clk) begin
    if (push) fifo_mem_q[fifo_wr_q] <= rx_byte;
    cpu_adr_q <= cpu_adr_d;
    cpu_dat_q <= cpu_dat_d;
    cpu_sel_q <= cpu_sel_d;
    cpu_we_q  <= cpu_we_d;
  end
endmodule
